// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI RAM read master.
package spi_pkg;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam int         FRAME_BITS     = 32;
  localparam int         DATA_START_BIT = 24;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    GAP
  } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: phase_end strobes on the last of every CLK_DIV enabled cycles.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase_end
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign phase_end = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || phase_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_ram_reader.sv
// SPI mode-0 master issuing single-byte READ (0x03) frames to a 16-bit-addressed SPI RAM.
module spi_ram_reader
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] DATA_BIT0 = 6'(DATA_START_BIT);

  state_e      state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        phase_end;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != IDLE),
    .clr       (state_q == IDLE),
    .phase_end (phase_end)
  );

  always_comb begin
    // NOTE: every signal gets a hold default first, so no path through the case infers a latch.
    state_d = state_q;
    tx_d    = tx_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = {CMD_READ, addr, 8'h00};
          bit_d   = '0;
          rx_d    = '0;
          cs_n_d  = 1'b0;
          mosi_d  = CMD_READ[7];
          busy_d  = 1'b1;
          state_d = LEAD;
        end
      end

      LEAD: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (phase_end) begin
          sck_d   = 1'b0;
          tx_d    = tx_q << 1;
          // The data byte is a read phase: hold mosi low while the RAM drives miso.
          mosi_d  = ((bit_q + 6'd1) >= DATA_BIT0) ? 1'b0 : tx_q[30];
          state_d = LOW;
        end
      end

      LOW: begin
        if (phase_end) begin
          if (bit_q == LAST_BIT) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            rdata_d = rx_q;
            state_d = GAP;
          end else begin
            bit_d = bit_q + 6'd1;
            sck_d = 1'b1;
            // miso is captured on the edge that raises sck; it has been stable a full half-period.
            if (bit_d >= DATA_BIT0) begin
              rx_d = {rx_q[6:0], miso};
            end
            state_d = HIGH;
          end
        end
      end

      GAP: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign cs_n  = cs_n_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_ram_reader.sv
// Directed bench: three readers (CLK_DIV 2, 1, 7), each against its own behavioural SPI RAM.
module tb_spi_ram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a [3];
  logic [15:0] addr_a  [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [7:0]  rdata_a [3];
  logic        cs_n_a  [3];
  logic        sck_a   [3];
  logic        mosi_a  [3];
  int          rise_a  [3];
  logic [23:0] hdr_a   [3];
  int          gap_a   [3];

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    logic        miso     = 1'b0;
    int          rise_cnt = 0;
    logic [23:0] shift    = '0;
    logic [23:0] hdr      = '0;
    int          gap_cnt  = 0;
    int          last_gap = 0;
    logic [7:0]  byte_v;

    spi_ram_reader #(
      .CLK_DIV (D)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_a[g]),
      .addr  (addr_a[g]),
      .busy  (busy_a[g]),
      .done  (done_a[g]),
      .rdata (rdata_a[g]),
      .cs_n  (cs_n_a[g]),
      .sck   (sck_a[g]),
      .mosi  (mosi_a[g]),
      .miso  (miso)
    );

    // SPI RAM model: samples mosi on SCK rise, shifts data out on SCK fall.
    always @(negedge cs_n_a[g]) begin
      rise_cnt = 0;
      shift    = '0;
    end

    always @(posedge sck_a[g]) begin
      if (!cs_n_a[g]) begin
        shift = {shift[22:0], mosi_a[g]};
        rise_cnt++;
        if (rise_cnt == 24) hdr = shift;
      end
    end

    always @(negedge sck_a[g]) begin
      if (!cs_n_a[g] && rise_cnt >= 24 && rise_cnt < 32) begin
        byte_v = mem[hdr[7:0]];
        miso   = byte_v[3'(31 - rise_cnt)];
      end
    end

    always @(negedge clk) begin
      if (cs_n_a[g]) begin
        gap_cnt++;
      end else begin
        if (gap_cnt != 0) last_gap = gap_cnt;
        gap_cnt = 0;
      end
    end

    assign rise_a[g] = rise_cnt;
    assign hdr_a[g]  = hdr;
    assign gap_a[g]  = last_gap;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full read on reader k; optional mid-transfer start pulse at cycle poke_cyc.
  task automatic run_read(input int k, input int d, input logic [15:0] a,
                          input logic [7:0] exp_data, input bit immediate,
                          input int poke_cyc, input logic [15:0] poke_addr,
                          input string tag);
    int cyc;
    int done_cyc;
    int ndone;
    logic [7:0] got;
    if (!immediate) @(negedge clk);
    addr_a[k]  = a;
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    ndone    = 0;
    got      = 8'h00;
    while (busy_a[k] === 1'b1 && cyc < 70 * d + 20) begin
      if (done_a[k] === 1'b1) begin
        ndone++;
        done_cyc = cyc;
        got      = rdata_a[k];
        check({tag, " cs_n at done"}, 32'(cs_n_a[k]), 32'd1);
      end
      if (cyc == poke_cyc) begin
        start_a[k] = 1'b1;
        addr_a[k]  = poke_addr;
      end else begin
        start_a[k] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_a[k] = 1'b0;
    check({tag, " done count"}, 32'(ndone), 32'd1);
    check({tag, " done cycle"}, 32'(done_cyc), 32'(65 * d + 1));
    check({tag, " busy clear cycle"}, 32'(cyc), 32'(66 * d + 1));
    check({tag, " rdata"}, 32'(got), 32'(exp_data));
    check({tag, " rdata held"}, 32'(rdata_a[k]), 32'(exp_data));
    check({tag, " sck rises"}, 32'(rise_a[k]), 32'd32);
    check({tag, " mosi header"}, 32'(hdr_a[k]), {8'h00, 8'h03, a});
  endtask

  initial begin
    int busy_cycles;
    int ndone;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h55);
    mem[8'h5A] = 8'hC3;
    mem[8'h00] = 8'h00;
    mem[8'hFF] = 8'hFF;
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'h99;
    mem[8'h03] = 8'hA5;
    mem[8'h80] = 8'h6E;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b1;
      addr_a[k]  = 16'h1234;
    end

    // Reset held with start asserted: everything stays idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("reset cs_n k%0d c%0d", k, c), 32'(cs_n_a[k]), 32'd1);
        check($sformatf("reset sck k%0d c%0d", k, c), 32'(sck_a[k]), 32'd0);
        check($sformatf("reset mosi k%0d c%0d", k, c), 32'(mosi_a[k]), 32'd0);
        check($sformatf("reset busy k%0d c%0d", k, c), 32'(busy_a[k]), 32'd0);
        check($sformatf("reset done k%0d c%0d", k, c), 32'(done_a[k]), 32'd0);
        check($sformatf("reset rdata k%0d c%0d", k, c), 32'(rdata_a[k]), 32'd0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) start_a[k] = 1'b0;
    repeat (2) @(negedge clk);
    check("post reset cs_n", 32'(cs_n_a[0]), 32'd1);
    check("post reset busy", 32'(busy_a[0]), 32'd0);

    run_read(0, 2, 16'h005A, 8'hC3, 1'b0, -1, 16'h0000, "basic");

    run_read(0, 2, 16'h0000, 8'h00, 1'b0, -1, 16'h0000, "b2b first");
    run_read(0, 2, 16'h00FF, 8'hFF, 1'b1, -1, 16'h0000, "b2b second");
    check("b2b deselect >= D", 32'(gap_a[0] >= 2), 32'd1);

    run_read(0, 2, 16'h0010, 8'h3C, 1'b0, 40, 16'h0011, "ignored start");
    busy_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a[0] !== 1'b0 || cs_n_a[0] !== 1'b1) busy_cycles++;
    end
    check("ignored start no second frame", 32'(busy_cycles), 32'd0);

    // Abort: reset during cycle 70 of a transfer.
    @(negedge clk);
    addr_a[0]  = 16'h0003;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    ndone = 0;
    for (int c = 1; c < 70; c++) begin
      if (done_a[0] === 1'b1) ndone++;
      @(negedge clk);
    end
    check("abort cs_n low before reset", 32'(cs_n_a[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort cs_n", 32'(cs_n_a[0]), 32'd1);
    check("abort sck", 32'(sck_a[0]), 32'd0);
    check("abort busy", 32'(busy_a[0]), 32'd0);
    check("abort rdata", 32'(rdata_a[0]), 32'd0);
    for (int c = 0; c < 10; c++) begin
      if (done_a[0] === 1'b1) ndone++;
      @(negedge clk);
    end
    check("abort no done", 32'(ndone), 32'd0);
    run_read(0, 2, 16'h0003, 8'hA5, 1'b0, -1, 16'h0000, "after abort");

    run_read(1, 1, 16'h0080, 8'h6E, 1'b0, -1, 16'h0000, "div1");
    run_read(2, 7, 16'h0080, 8'h6E, 1'b0, -1, 16'h0000, "div7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
